sevenseg_scan: RTL and testbench

Multiplexed, parametrised seven-segment display controller that time-shares one segment bus across `NUM_DIGITS` common-anode digits. Each digit takes a 5-bit code: hex glyphs 0–F, or blank for codes 16 and above. Per-digit decimal points, leading-zero suppression, an anti-ghosting guard interval and frame-synchronous (tear-free) updates are provided. The block sits between the user datapath and the board's segment/anode pins and replaces per-digit static decoders.

---
 rtl/sevenseg_scan_if.sv | 38 +++
 rtl/sevenseg_scan.sv | 196 +++++++++++++++++++
 tb/tb_sevenseg_scan.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: user-side and pin-side signals of the seven-segment scan
// controller, grouped so the controller and its user share one port.
//   master : user datapath (drives digit codes, decimal points, lz_en, load;
//            observes pending and the display pins)
//   slave  : the scan controller (sevenseg_scan)
// Signals:
//   digits_in  [5*NUM_DIGITS] digit codes, digit i at [5i+4:5i], digit 0 rightmost
//   dp_in      [NUM_DIGITS]   decimal point request per digit, 1 = lit
//   lz_en                     leading-zero suppression enable, sampled with load
//   load                      single-cycle strobe capturing the three inputs above
//   pending                   staged data waiting for the next frame boundary
//   seg_out    [7]            segments {a,b,c,d,e,f,g}, active-low
//   dp_out                    decimal point, active-low
//   an_out     [NUM_DIGITS]   anode enables, active-low one-hot-cold
//   frame_done                one-cycle pulse after each frame boundary
interface sevenseg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [5*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic                    load;
  logic                    pending;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, lz_en, load,
    input  pending, seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  digits_in, dp_in, lz_en, load,
    output pending, seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed seven-segment display controller for NUM_DIGITS
// common-anode digits sharing one segment bus.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sevenseg_scan_if.slave (digit codes, dp, lz_en, load in;
//          pending, seg_out, dp_out, an_out, frame_done out)
// Each digit owns a slot of SLOT_CYCLES cycles: the first GUARD_CYCLES of the
// slot keep every anode off (anti-ghosting), the rest drive that digit.
// Loaded data waits in staging and is only copied to the display registers
// at the frame boundary, so a frame never shows a mix of old and new data.
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  sevenseg_scan_if.slave bus
);

  localparam int PW = $clog2(SLOT_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 5 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST   = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] P_GUARD  = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{5'd16}};
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;

  // Active-low abcdefg glyphs; codes 16..31 are blank.
  function automatic logic [6:0] hex_to_seg(input logic [4:0] code);
    logic [6:0] seg;
    seg = SEG_OFF;
    if (!code[4]) begin
      case (code[3:0])
        4'h0: seg = 7'b0000001;
        4'h1: seg = 7'b1001111;
        4'h2: seg = 7'b0010010;
        4'h3: seg = 7'b0000110;
        4'h4: seg = 7'b1001100;
        4'h5: seg = 7'b0100100;
        4'h6: seg = 7'b0100000;
        4'h7: seg = 7'b0001111;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0000100;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b1100000;
        4'hC: seg = 7'b0110001;
        4'hD: seg = 7'b1000010;
        4'hE: seg = 7'b0110000;
        default: seg = 7'b0111000;
      endcase
    end
    return seg;
  endfunction

  // Scan counters
  logic [PW-1:0]         p_q, p_d;
  logic [IW-1:0]         idx_q, idx_d;
  // Staging and display registers
  logic [DW-1:0]         stg_digits_q, stg_digits_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d;
  logic                  stg_lz_q, stg_lz_d;
  logic [DW-1:0]         disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  disp_lz_q, disp_lz_d;
  // Registered outputs
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  p_wrap;
  logic                  boundary;
  logic                  drive;

  // Counter, staging and display next-state
  always_comb begin
    p_wrap   = (p_q == P_LAST);
    boundary = p_wrap && (idx_q == IDX_LAST);

    p_d   = p_wrap ? '0 : p_q + 1'b1;
    idx_d = idx_q;
    if (p_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_lz_d     = stg_lz_q;
    if (bus.load) begin
      stg_digits_d = bus.digits_in;
      stg_dp_d     = bus.dp_in;
      stg_lz_d     = bus.lz_en;
    end

    // The display takes the pre-edge staging contents, so a load on the
    // boundary edge lands in staging and waits for the following frame.
    disp_digits_d = disp_digits_q;
    disp_dp_d     = disp_dp_q;
    disp_lz_d     = disp_lz_q;
    if (boundary && pending_q) begin
      disp_digits_d = stg_digits_q;
      disp_dp_d     = stg_dp_q;
      disp_lz_d     = stg_lz_q;
    end

    pending_d    = bus.load | (pending_q & ~boundary);
    frame_done_d = boundary;
  end

  // Per-digit decode from the post-edge display registers, so the pins
  // track the counters without a cycle of lag.
  logic [NUM_DIGITS-1:0] zero_or_blank;
  logic [NUM_DIGITS-1:0] supp;
  logic [6:0]            glyph_w [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [4:0] code;
    assign code              = disp_digits_d[5*gi +: 5];
    assign zero_or_blank[gi] = code[4] | (code[3:0] == 4'd0);
    assign glyph_w[gi]       = supp[gi] ? SEG_OFF : hex_to_seg(code);
  end

  // A digit is suppressed when it and every digit above it is zero or blank;
  // digit 0 is never suppressed so a value of zero still shows "0".
  always_comb begin
    logic run;
    run  = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run     = run & zero_or_blank[i];
      supp[i] = disp_lz_d & run;
    end
  end

  always_comb begin
    logic [6:0] sel_glyph;
    logic       sel_dp;
    drive     = (p_d >= P_GUARD);
    sel_glyph = SEG_OFF;
    sel_dp    = 1'b0;
    an_d      = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        sel_glyph = glyph_w[i];
        sel_dp    = disp_dp_d[i];
        an_d[i]   = ~drive;
      end
    end
    seg_d = drive ? sel_glyph : SEG_OFF;
    dp_d  = drive ? ~sel_dp : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q           <= '0;
      idx_q         <= '0;
      stg_digits_q  <= ALL_BLANK;
      stg_dp_q      <= '0;
      stg_lz_q      <= 1'b0;
      disp_digits_q <= ALL_BLANK;
      disp_dp_q     <= '0;
      disp_lz_q     <= 1'b0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      p_q           <= p_d;
      idx_q         <= idx_d;
      stg_digits_q  <= stg_digits_d;
      stg_dp_q      <= stg_dp_d;
      stg_lz_q      <= stg_lz_d;
      disp_digits_q <= disp_digits_d;
      disp_dp_q     <= disp_dp_d;
      disp_lz_q     <= disp_lz_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed bench for sevenseg_scan with 4 digits,
// 10-cycle slots and a 2-cycle guard (40-cycle frames). Expected digit
// displays are pushed to a scoreboard when data is loaded and popped while
// each frame is scanned.
module tb_sevenseg_scan;
  localparam int N     = 4;
  localparam int SLOT  = 10;
  localparam int GUARD = 2;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  logic rst_n;

  sevenseg_scan_if #(.NUM_DIGITS(N)) bus_if ();

  sevenseg_scan #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SLOT),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_pos(input int t);
    while ((cyc % FRAME) != t) step();
  endtask

  // Reference model of one displayed frame.
  task automatic push_frame(input logic [19:0] codes, input logic [3:0] dp, input logic lz);
    exp_t e;
    for (int d = 0; d < N; d++) begin
      logic [4:0] c;
      logic       sup;
      c   = codes[5*d +: 5];
      sup = lz && (d >= 1);
      for (int j = d; j < N; j++) begin
        logic [4:0] cj;
        cj = codes[5*j +: 5];
        if (!(cj == 5'd0 || cj >= 5'd16)) sup = 1'b0;
      end
      e.an    = 4'hF;
      e.an[d] = 1'b0;
      e.seg   = (sup || c >= 5'd16) ? 7'h7F : glyph[c[3:0]];
      e.dp    = ~dp[d];
      sb.push_back(e);
      $display("push d%0d an=%b seg=%b dp=%b", d, e.an, e.seg, e.dp);
    end
  endtask

  task automatic do_load(input logic [19:0] codes, input logic [3:0] dp,
                         input logic lz, input bit push);
    bus_if.digits_in = codes;
    bus_if.dp_in     = dp;
    bus_if.lz_en     = lz;
    bus_if.load      = 1'b1;
    if (push) push_frame(codes, dp, lz);
    step();
    bus_if.load = 1'b0;
    $display("load codes=%h dp=%b lz=%b at pos %0d", codes, dp, lz, cyc % FRAME);
    chk("pending_after_load", bus_if.pending, 1);
  endtask

  // Scan one frame starting at the next (or current) boundary.
  task automatic check_frame(input bit exp_pend);
    exp_t e;
    if ((cyc % FRAME) != 0) goto_pos(0);
    chk("frame_done_at_boundary", bus_if.frame_done, 1);
    chk("pending_at_boundary", bus_if.pending, exp_pend);
    for (int d = 0; d < N; d++) begin
      goto_pos(d * SLOT + GUARD - 1);
      chk($sformatf("guard_an_d%0d", d), bus_if.an_out, 4'hF);
      chk($sformatf("guard_seg_d%0d", d), bus_if.seg_out, 7'h7F);
      chk($sformatf("guard_dp_d%0d", d), bus_if.dp_out, 1);
      if (d == 0) chk("frame_done_one_cycle", bus_if.frame_done, 0);
      chk("scoreboard_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        goto_pos(d * SLOT + GUARD);
        chk($sformatf("an_d%0d", d), bus_if.an_out, e.an);
        chk($sformatf("seg_d%0d", d), bus_if.seg_out, e.seg);
        chk($sformatf("dp_d%0d", d), bus_if.dp_out, e.dp);
        goto_pos(d * SLOT + 5);
        chk($sformatf("an_mid_d%0d", d), bus_if.an_out, e.an);
        chk($sformatf("seg_mid_d%0d", d), bus_if.seg_out, e.seg);
        $display("frame d%0d an=%b seg=%b dp=%b", d, bus_if.an_out, bus_if.seg_out, bus_if.dp_out);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus_if.digits_in = '0;
    bus_if.dp_in     = '0;
    bus_if.lz_en     = 1'b0;
    bus_if.load      = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", bus_if.an_out, 4'hF);
    chk("rst_seg", bus_if.seg_out, 7'h7F);
    chk("rst_dp", bus_if.dp_out, 1);
    chk("rst_pending", bus_if.pending, 0);
    chk("rst_frame_done", bus_if.frame_done, 0);
    rst_n = 1'b1;
    cyc   = 0;
    $display("reset released");

    // First frame with blank display: guard timing and frame_done at edge 40
    for (int k = 1; k <= FRAME + 1; k++) begin
      logic [3:0] exp_an;
      step();
      exp_an = 4'hF;
      if ((k % SLOT) >= GUARD) exp_an[(k / SLOT) % N] = 1'b0;
      chk($sformatf("first_an_k%0d", k), bus_if.an_out, exp_an);
      chk($sformatf("first_seg_k%0d", k), bus_if.seg_out, 7'h7F);
      chk($sformatf("first_fd_k%0d", k), bus_if.frame_done, (k == FRAME) ? 1 : 0);
    end
    $display("first frame scanned");

    // Hex glyphs with a decimal point on digit 2
    do_load({5'd15, 5'd10, 5'd8, 5'd0}, 4'b0100, 1'b0, 1'b1);
    check_frame(1'b0);

    // Tear-free: load during digit 2; digits 2 and 3 keep old glyphs
    goto_pos(25);
    chk("tear_an_d2", bus_if.an_out, 4'b1011);
    chk("tear_seg_d2_old", bus_if.seg_out, 7'b0001000);
    chk("tear_dp_d2_old", bus_if.dp_out, 0);
    do_load({5'd1, 5'd2, 5'd3, 5'd4}, 4'b0001, 1'b0, 1'b1);
    chk("tear_seg_d2_after_load", bus_if.seg_out, 7'b0001000);
    goto_pos(35);
    chk("tear_an_d3", bus_if.an_out, 4'b0111);
    chk("tear_seg_d3_old", bus_if.seg_out, 7'b0111000);
    goto_pos(39);
    chk("tear_pending_before_boundary", bus_if.pending, 1);
    check_frame(1'b0);

    // Load W mid-frame, X on the boundary edge, Y mid-frame: W then Y show
    do_load({5'd16, 5'd16, 5'd7, 5'd9}, 4'b0010, 1'b0, 1'b1);
    goto_pos(FRAME - 1);
    do_load({5'd5, 5'd5, 5'd5, 5'd5}, 4'b1111, 1'b0, 1'b0);
    check_frame(1'b1);
    do_load({5'd11, 5'd12, 5'd13, 5'd14}, 4'b1001, 1'b1, 1'b1);
    check_frame(1'b0);

    // Leading-zero suppression
    do_load({5'd0, 5'd0, 5'd5, 5'd0}, 4'b0000, 1'b1, 1'b1);
    check_frame(1'b0);
    do_load({5'd0, 5'd0, 5'd0, 5'd0}, 4'b1000, 1'b1, 1'b1);
    check_frame(1'b0);

    // Asynchronous reset during DRIVE discards staged data
    goto_pos(5);
    chk("pre_rst_an", bus_if.an_out, 4'b1110);
    chk("pre_rst_seg", bus_if.seg_out, 7'b0000001);
    do_load({5'd6, 5'd6, 5'd6, 5'd6}, 4'b1111, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", bus_if.an_out, 4'hF);
    chk("async_rst_seg", bus_if.seg_out, 7'h7F);
    chk("async_rst_dp", bus_if.dp_out, 1);
    chk("async_rst_pending", bus_if.pending, 0);
    chk("async_rst_frame_done", bus_if.frame_done, 0);
    $display("async reset asserted mid-drive");
    @(posedge clk);
    #1;
    chk("held_rst_an", bus_if.an_out, 4'hF);
    rst_n = 1'b1;
    cyc   = 0;
    push_frame({5'd16, 5'd16, 5'd16, 5'd16}, 4'b0000, 1'b0);
    step();
    chk("post_rst_pending", bus_if.pending, 0);
    check_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
